// File: rtl/cube_move_engine.sv
// Rubik's cube move engine: holds a 54-sticker working state and applies
// face turns one CW quarter turn per clock. A frame-synchronised snapshot is
// exposed for display, so the display never shows a half-finished move.
module cube_move_engine (
   input  logic         clk,
   input  logic         rst,
   input  logic         move_valid,
   input  logic [2:0]   move_face,
   input  logic [1:0]   move_dir,
   output logic         move_ready,
   input  logic         solve_req,
   input  logic         frame_sync,
   output logic [161:0] color,
   output logic         move_done,
   output logic         move_err,
   output logic [15:0]  move_count,
   output logic         solved
);

   localparam int unsigned N_FACE    = 6;
   localparam int unsigned N_POS     = 9;
   localparam int unsigned N_STK     = N_FACE * N_POS;
   localparam int unsigned CODE_W    = 3;
   localparam int unsigned VEC_W     = N_STK * CODE_W;
   localparam int unsigned CNT_W     = 16;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // Solved cube: every sticker carries the colour code of its own face.
   function automatic logic [VEC_W-1:0] solved_pattern();
      logic [VEC_W-1:0] p;
      p = '0;
      for (int k = 0; k < int'(N_STK); k++) begin
         p[CODE_W*k +: CODE_W] = CODE_W'(k / int'(N_POS));
      end
      return p;
   endfunction

   localparam logic [VEC_W-1:0] SOLVED = solved_pattern();

   // Own-face 4-cycles of a CW quarter turn (corners, then edges).
   localparam int unsigned CORNER [4] = '{0, 2, 8, 6};
   localparam int unsigned EDGE   [4] = '{1, 5, 7, 3};

   // Adjacent strips per face (absolute sticker indices), four strips of
   // three; a CW turn moves strip i into strip i+1 (wrapping 3 -> 0).
   localparam int unsigned STRIP [6][12] = '{
      '{18, 19, 20,   9, 10, 11,  36, 37, 38,  27, 28, 29},  // U
      '{ 0,  3,  6,  18, 21, 24,  45, 48, 51,  44, 41, 38},  // L
      '{ 6,  7,  8,  27, 30, 33,  47, 46, 45,  17, 14, 11},  // F
      '{20, 23, 26,   2,  5,  8,  42, 39, 36,  47, 50, 53},  // R
      '{ 2,  1,  0,   9, 12, 15,  51, 52, 53,  35, 32, 29},  // B
      '{24, 25, 26,  33, 34, 35,  42, 43, 44,  15, 16, 17}   // D
   };

   typedef enum logic {IDLE, TURN} state_t;

   state_t           state;
   logic [VEC_W-1:0] work;
   logic [VEC_W-1:0] turned;
   logic [2:0]       face_q;
   logic [1:0]       turns_left;
   logic             move_ok;
   logic [1:0]       turns_init;

   // Decode the incoming request: legality and number of CW quarter turns.
   always_comb begin
      move_ok    = (move_face < 3'(N_FACE)) && (move_dir != 2'b11);
      turns_init = 2'd3;
      case (move_dir)
         2'b00:   turns_init = 2'd1;
         2'b10:   turns_init = 2'd2;
         default: turns_init = 2'd3;
      endcase
   end

   // Working state after one CW quarter turn of the latched face.
   always_comb begin
      turned = work;
      for (int f = 0; f < int'(N_FACE); f++) begin
         if (face_q == 3'(f)) begin
            for (int i = 0; i < 4; i++) begin
               turned[CODE_W*(f*int'(N_POS) + int'(CORNER[(i+1)%4])) +: CODE_W] =
                  work[CODE_W*(f*int'(N_POS) + int'(CORNER[i])) +: CODE_W];
               turned[CODE_W*(f*int'(N_POS) + int'(EDGE[(i+1)%4])) +: CODE_W] =
                  work[CODE_W*(f*int'(N_POS) + int'(EDGE[i])) +: CODE_W];
               for (int j = 0; j < 3; j++) begin
                  turned[CODE_W*int'(STRIP[f][((i+1)%4)*3 + j]) +: CODE_W] =
                     work[CODE_W*int'(STRIP[f][i*3 + j]) +: CODE_W];
               end
            end
         end
      end
   end

   // Move FSM, working state, display snapshot and status outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         work       <= SOLVED;
         color      <= SOLVED;
         face_q     <= '0;
         turns_left <= '0;
         move_ready <= 1'b1;
         move_done  <= 1'b0;
         move_err   <= 1'b0;
         move_count <= '0;
      end else begin
         move_done <= 1'b0;
         move_err  <= 1'b0;
         case (state)
            IDLE: begin
               if (solve_req) begin
                  work       <= SOLVED;
                  move_count <= '0;
               end else if (move_valid) begin
                  if (move_ok) begin
                     face_q     <= move_face;
                     turns_left <= turns_init;
                     state      <= TURN;
                     move_ready <= 1'b0;
                  end else begin
                     move_err <= 1'b1;
                  end
               end
               // Snapshot reflects this cycle's solve load, if any.
               if (frame_sync) begin
                  color <= solve_req ? SOLVED : work;
               end
            end
            TURN: begin
               work       <= turned;
               turns_left <= turns_left - 2'd1;
               if (turns_left == 2'd1) begin
                  state      <= IDLE;
                  move_ready <= 1'b1;
                  move_done  <= 1'b1;
                  if (move_count != CNT_MAX) begin
                     move_count <= move_count + CNT_W'(1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Solved flag tracks the live working state, not the display copy.
   assign solved = (work == SOLVED);

endmodule

// File: tb/tb_cube_move_engine.sv
// Randomised self-checking bench for cube_move_engine against a sticker-array
// reference model built from face/position adjacency and grid rotation.
module tb_cube_move_engine;

   logic         clk = 1'b0;
   logic         rst;
   logic         move_valid;
   logic [2:0]   move_face;
   logic [1:0]   move_dir;
   logic         move_ready;
   logic         solve_req;
   logic         frame_sync;
   logic [161:0] color;
   logic         move_done;
   logic         move_err;
   logic [15:0]  move_count;
   logic         solved;

   int n_checks = 0;
   int n_errors = 0;

   int m_work  [54];
   int m_color [54];
   int m_count;

   // Adjacent strips: which face and which positions, in CW travel order.
   localparam int SF [6][4] = '{
      '{2, 1, 4, 3}, '{0, 2, 5, 4}, '{0, 3, 5, 1},
      '{2, 0, 4, 5}, '{0, 1, 5, 3}, '{2, 3, 4, 1}
   };
   localparam int SP [6][4][3] = '{
      '{'{0,1,2}, '{0,1,2}, '{0,1,2}, '{0,1,2}},
      '{'{0,3,6}, '{0,3,6}, '{0,3,6}, '{8,5,2}},
      '{'{6,7,8}, '{0,3,6}, '{2,1,0}, '{8,5,2}},
      '{'{2,5,8}, '{2,5,8}, '{6,3,0}, '{2,5,8}},
      '{'{2,1,0}, '{0,3,6}, '{6,7,8}, '{8,5,2}},
      '{'{6,7,8}, '{6,7,8}, '{6,7,8}, '{6,7,8}}
   };

   cube_move_engine dut (
      .clk        (clk),
      .rst        (rst),
      .move_valid (move_valid),
      .move_face  (move_face),
      .move_dir   (move_dir),
      .move_ready (move_ready),
      .solve_req  (solve_req),
      .frame_sync (frame_sync),
      .color      (color),
      .move_done  (move_done),
      .move_err   (move_err),
      .move_count (move_count),
      .solved     (solved)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [161:0] got, input logic [161:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [161:0] pack(input int a [54]);
      logic [161:0] v;
      v = '0;
      for (int k = 0; k < 54; k++) v[3*k +: 3] = 3'(a[k]);
      return v;
   endfunction

   task automatic m_reset();
      for (int k = 0; k < 54; k++) m_work[k] = k / 9;
      m_count = 0;
   endtask

   function automatic bit m_is_solved();
      for (int k = 0; k < 54; k++) if (m_work[k] != k / 9) return 1'b0;
      return 1'b1;
   endfunction

   // One CW quarter turn: rotate the face grid, then pass each strip along.
   task automatic m_quarter(input int f);
      int old [54];
      old = m_work;
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++)
            m_work[f*9 + r*3 + c] = old[f*9 + (2-c)*3 + r];
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 3; j++)
            m_work[SF[f][(i+1)%4]*9 + SP[f][(i+1)%4][j]] = old[SF[f][i]*9 + SP[f][i][j]];
   endtask

   task automatic pulse_frame();
      @(negedge clk);
      frame_sync = 1'b1;
      @(negedge clk);
      frame_sync = 1'b0;
      m_color = m_work;
      check("frame_color", color, pack(m_color));
   endtask

   task automatic do_move(input int f, input int d, input bit fs_mid);
      int  turns;
      int  low;
      bit  seen;
      turns = (d == 0) ? 1 : (d == 2) ? 2 : 3;
      @(negedge clk);
      check("ready_idle", move_ready, 1);
      move_valid = 1'b1;
      move_face  = 3'(f);
      move_dir   = 2'(d);
      @(negedge clk);
      move_valid = 1'b0;
      if (fs_mid) frame_sync = 1'b1;
      low  = 0;
      seen = 1'b0;
      for (int c = 0; c < 8 && !seen; c++) begin
         if (move_done) begin
            seen = 1'b1;
         end else begin
            if (!move_ready) low++;
            // Requests during the turn must be ignored.
            move_valid = 1'($urandom);
            solve_req  = 1'($urandom);
            move_face  = 3'($urandom);
            move_dir   = 2'($urandom);
            @(negedge clk);
            frame_sync = 1'b0;
         end
      end
      move_valid = 1'b0;
      solve_req  = 1'b0;
      frame_sync = 1'b0;
      check("done_seen", seen, 1);
      check("ready_low", low, turns);
      for (int t = 0; t < turns; t++) m_quarter(f);
      if (m_count < 65535) m_count++;
      check("count", move_count, m_count);
      check("solved", solved, m_is_solved());
      if (fs_mid) check("color_hold", color, pack(m_color));
      @(negedge clk);
      check("done_pulse", move_done, 0);
   endtask

   task automatic bad_move(input int f, input int d);
      @(negedge clk);
      check("bad_ready_in", move_ready, 1);
      move_valid = 1'b1;
      move_face  = 3'(f);
      move_dir   = 2'(d);
      @(negedge clk);
      move_valid = 1'b0;
      check("err_pulse", move_err, 1);
      check("err_ready", move_ready, 1);
      check("err_count", move_count, m_count);
      check("err_done", move_done, 0);
      check("err_solved", solved, m_is_solved());
      @(negedge clk);
      check("err_once", move_err, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      int dirs [3] = '{0, 1, 2};
      int r;
      logic [161:0] snap;

      rst        = 1'b0;
      move_valid = 1'b0;
      move_face  = '0;
      move_dir   = '0;
      solve_req  = 1'b0;
      frame_sync = 1'b0;
      m_reset();
      m_color = m_work;
      repeat (3) @(negedge clk);
      check("rst_color", color, pack(m_color));
      check("rst_count", move_count, 0);
      check("rst_solved", solved, 1);
      check("rst_ready", move_ready, 1);
      check("rst_done", move_done, 0);
      check("rst_err", move_err, 0);
      rst = 1'b1;

      // Post-reset snapshot.
      pulse_frame();
      snap = color;
      check("stk0", snap[2:0], 0);
      check("stk18", snap[56:54], 2);
      check("stk53", snap[161:159], 5);

      // U CW.
      do_move(0, 0, 1'b0);
      pulse_frame();
      snap = color;
      for (int k = 18; k <= 20; k++) check("u_cw_f", snap[3*k +: 3], 3);
      for (int k = 9; k <= 11; k++)  check("u_cw_l", snap[3*k +: 3], 2);
      check("u_cw_solved", solved, 0);

      // Back to solved with a fresh count via solve.
      @(negedge clk);
      solve_req = 1'b1;
      @(negedge clk);
      solve_req = 1'b0;
      m_reset();
      check("solve_count", move_count, 0);
      check("solve_solved", solved, 1);
      pulse_frame();

      // R CCW (frame_sync mid-turn ignored) then R CW.
      do_move(3, 1, 1'b1);
      do_move(3, 0, 1'b0);
      check("r_inv_solved", solved, 1);
      check("r_inv_count", move_count, 2);

      // F half twice, then invalid moves.
      do_move(2, 2, 1'b0);
      do_move(2, 2, 1'b1);
      check("f2f2_solved", solved, 1);
      bad_move(6, 0);
      bad_move(1, 3);
      bad_move(7, 3);

      // Five moves, then solve together with a move request.
      for (int i = 0; i < 5; i++) do_move(int'($urandom % 6), dirs[$urandom % 3], 1'($urandom));
      @(negedge clk);
      solve_req  = 1'b1;
      move_valid = 1'b1;
      move_face  = 3'($urandom % 6);
      move_dir   = 2'b00;
      @(negedge clk);
      solve_req  = 1'b0;
      move_valid = 1'b0;
      m_reset();
      check("sv_ready", move_ready, 1);
      check("sv_count", move_count, 0);
      check("sv_solved", solved, 1);
      check("sv_done", move_done, 0);
      @(negedge clk);
      check("sv_done2", move_done, 0);
      check("sv_ready2", move_ready, 1);
      pulse_frame();

      // Scramble a little, then reset in the middle of a CCW turn.
      do_move(4, 0, 1'b0);
      do_move(5, 2, 1'b0);
      @(negedge clk);
      move_valid = 1'b1;
      move_face  = 3'd3;
      move_dir   = 2'b01;
      @(negedge clk);
      move_valid = 1'b0;
      @(negedge clk);
      check("mid_ready", move_ready, 0);
      #2 rst = 1'b0;
      #1;
      m_reset();
      m_color = m_work;
      check("ar_solved", solved, 1);
      check("ar_count", move_count, 0);
      check("ar_ready", move_ready, 1);
      check("ar_color", color, pack(m_color));
      check("ar_done", move_done, 0);
      @(negedge clk);
      rst = 1'b1;
      pulse_frame();
      do_move(1, 0, 1'b0);

      // Randomised traffic.
      for (int i = 0; i < 40; i++) begin
         r = int'($urandom % 10);
         if (r == 0)      bad_move(6 + int'($urandom % 2), int'($urandom % 4));
         else if (r == 1) bad_move(int'($urandom % 6), 3);
         else if (r == 2) pulse_frame();
         else             do_move(int'($urandom % 6), dirs[$urandom % 3], 1'($urandom));
      end
      pulse_frame();
      check("final_solved", solved, m_is_solved());
      check("final_count", move_count, m_count);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
